// File: rtl/reg_bank_param.sv
// Parametrised register file: one write port with half-word field control, two registered
// read ports with write-to-read bypass, and a sequential bank-clear engine.
module reg_bank_param #(
   parameter int              DW     = 64,
   parameter int              NREGS  = 16,
   parameter int              AW     = $clog2(NREGS),
   parameter logic [DW-1:0]   CNST_A = '0,
   parameter logic [DW-1:0]   CNST_B = '1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          regwe,
   input  logic [DW-1:0] inA,
   input  logic [AW-1:0] selwreg,
   input  logic [1:0]    endreg,
   output logic [DW-1:0] outA,
   output logic [DW-1:0] outB,
   input  logic [AW-1:0] seloutA,
   input  logic [AW-1:0] seloutB,
   input  logic          cnstA,
   input  logic          cnstB,
   input  logic          enrregA,
   input  logic          enrregB,
   input  logic          clr_req,
   output logic          busy,
   output logic          wr_drop
);

   localparam int            HW       = DW / 2;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {
      IDLE,
      CLEAR
   } stateType;

   stateType      state, stateNext;
   logic [AW-1:0] clrIdx, clrIdxNext;
   logic          busyNext;

   logic [DW-1:0] regFile [NREGS];
   logic [DW-1:0] curVal;
   logic [DW-1:0] wrVal;
   logic [DW-1:0] nextA, nextB;
   logic          writeCommit;
   logic          writeDrop;
   logic          clearing;

   // A pending clear request wins over a same-cycle user write.
   assign clearing    = (state == CLEAR);
   assign writeCommit = regwe && (state == IDLE) && !clr_req;
   assign writeDrop   = regwe && (clearing || clr_req);

   // NOTE: every variable gets a default at the top of an always_comb so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      curVal = regFile[selwreg];
      wrVal  = inA;
      case (endreg)
         2'b00: wrVal = inA;
         2'b10: wrVal = {curVal[DW-1:HW], inA[HW-1:0]};
         2'b01: wrVal = {inA[DW-1:HW], curVal[HW-1:0]};
         2'b11: wrVal = {curVal[HW-1:0], curVal[DW-1:HW]};
      endcase
   end

   // Read-side view of the bank after this cycle's write or clear step commits.
   always_comb begin
      nextA = regFile[seloutA];
      if (clearing && (clrIdx == seloutA)) nextA = '0;
      if (writeCommit && (selwreg == seloutA)) nextA = wrVal;

      nextB = regFile[seloutB];
      if (clearing && (clrIdx == seloutB)) nextB = '0;
      if (writeCommit && (selwreg == seloutB)) nextB = wrVal;
   end

   always_comb begin
      stateNext  = state;
      clrIdxNext = clrIdx;
      busyNext   = busy;
      case (state)
         IDLE: begin
            if (clr_req) begin
               stateNext  = CLEAR;
               clrIdxNext = '0;
               busyNext   = 1'b1;
            end
         end
         CLEAR: begin
            if (clrIdx == LAST_IDX) begin
               stateNext  = IDLE;
               clrIdxNext = '0;
               busyNext   = 1'b0;
            end else begin
               clrIdxNext = clrIdx + AW'(1);
            end
         end
         default: begin
            stateNext  = IDLE;
            clrIdxNext = '0;
            busyNext   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         clrIdx  <= '0;
         busy    <= 1'b0;
         wr_drop <= 1'b0;
      end else begin
         state   <= stateNext;
         clrIdx  <= clrIdxNext;
         busy    <= busyNext;
         wr_drop <= writeDrop;
      end
   end

   // NOTE: the storage array is reset explicitly because an aborted clear must still leave
   // the whole bank at zero; this costs a reset pin per bit instead of a plain RAM.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      end else if (writeCommit) begin
         regFile[selwreg] <= wrVal;
      end else if (clearing) begin
         regFile[clrIdx] <= '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outA <= '0;
         outB <= '0;
      end else begin
         if (enrregA) outA <= cnstA ? CNST_A : nextA;
         if (enrregB) outB <= cnstB ? CNST_B : nextB;
      end
   end

endmodule
